// File: rtl/ex_stage_muldiv.sv
// Execute stage with EX/MEM pipeline register and a 32-step iterative
// multiply/divide unit that owns HI/LO and stalls upstream while running.
module ex_stage_muldiv #(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    input  logic [WIDTH-1:0] ReadData1,
    input  logic [WIDTH-1:0] ReadData2,
    input  logic [WIDTH-1:0] SignExtImm,
    input  logic             ALUSrc,
    input  logic [3:0]       AluCtrl,
    input  logic [4:0]       Shamt,
    input  logic             MemtoRegIn,
    input  logic             MemReadIn,
    input  logic             MemWriteIn,
    input  logic             RegWriteIn,
    input  logic [4:0]       WriteRegIn,
    output logic             Stall,
    output logic [WIDTH-1:0] AluResult,
    output logic [WIDTH-1:0] ReadData2Out,
    output logic             MemtoReg,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [4:0]       WriteReg,
    output logic             OutValid
);
    localparam int            CW   = $clog2(MD_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

    typedef enum logic [3:0] {
        OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SRL, OP_SRA, OP_SUB, OP_SLT,
        OP_SLTU, OP_XOR, OP_NOR, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHILO
    } alu_op_e;

    typedef enum logic {S_IDLE, S_RUN} md_state_e;

    md_state_e            r_state, w_state_next;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_p, w_p_next, w_prod;
    logic [WIDTH-1:0]     r_m, r_a, r_hi, r_lo;
    logic                 r_div, r_neg_res, r_neg_a, r_bzero;
    alu_op_e              w_op;
    logic [WIDTH-1:0]     w_b, w_alu, w_abs_a, w_abs_b, w_sub, w_q, w_r;
    logic [WIDTH:0]       w_sum, w_rem_sh;
    logic                 w_accept, w_is_md, w_sgn, w_last;

    assign w_op     = alu_op_e'(AluCtrl);
    assign Stall    = (r_state == S_RUN);
    assign w_accept = InValid & ~Stall;
    assign w_last   = Stall && (r_cnt == LAST);
    assign w_b      = ALUSrc ? SignExtImm : ReadData2;
    assign w_is_md  = w_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    assign w_sgn    = w_op inside {OP_MULT, OP_DIV};
    assign w_abs_a  = (w_sgn && ReadData1[WIDTH-1]) ? -ReadData1 : ReadData1;
    assign w_abs_b  = (w_sgn && w_b[WIDTH-1]) ? -w_b : w_b;

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_AND:    w_alu = ReadData1 & w_b;
            OP_OR:     w_alu = ReadData1 | w_b;
            OP_ADD:    w_alu = ReadData1 + w_b;
            OP_SLL:    w_alu = w_b << Shamt;
            OP_SRL:    w_alu = w_b >> Shamt;
            OP_SRA:    w_alu = $signed(w_b) >>> Shamt;
            OP_SUB:    w_alu = ReadData1 - w_b;
            OP_SLT:    w_alu = {{(WIDTH-1){1'b0}}, ($signed(ReadData1) < $signed(w_b))};
            OP_SLTU:   w_alu = {{(WIDTH-1){1'b0}}, (ReadData1 < w_b)};
            OP_XOR:    w_alu = ReadData1 ^ w_b;
            OP_NOR:    w_alu = ~(ReadData1 | w_b);
            OP_MFHILO: w_alu = ALUSrc ? r_lo : r_hi;
            default:   w_alu = '0;
        endcase
    end

    // Sign-magnitude iteration: the step works on magnitudes, signs are applied when HI/LO are written.
    always_comb begin
        w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
        w_rem_sh = r_p[2*WIDTH-1:WIDTH-1];
        w_sub    = w_rem_sh[WIDTH-1:0] - r_m;
        if (!r_div)
            w_p_next = r_p[0] ? {w_sum, r_p[WIDTH-1:1]} : {1'b0, r_p[2*WIDTH-1:1]};
        else if (w_rem_sh >= {1'b0, r_m})
            w_p_next = {w_sub, r_p[WIDTH-2:0], 1'b1};
        else
            w_p_next = {r_p[2*WIDTH-2:0], 1'b0};
        w_prod = r_neg_res ? -w_p_next : w_p_next;
        w_q    = r_neg_res ? -w_p_next[WIDTH-1:0] : w_p_next[WIDTH-1:0];
        w_r    = r_neg_a ? -w_p_next[2*WIDTH-1:WIDTH] : w_p_next[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_md) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt     <= '0;
            r_p       <= '0;
            r_m       <= '0;
            r_a       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_div     <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_a   <= 1'b0;
            r_bzero   <= 1'b0;
        end else if (w_accept && w_is_md) begin
            r_cnt     <= '0;
            r_div     <= (w_op == OP_DIV) || (w_op == OP_DIVU);
            r_neg_res <= w_sgn & (ReadData1[WIDTH-1] ^ w_b[WIDTH-1]);
            r_neg_a   <= w_sgn & ReadData1[WIDTH-1];
            r_bzero   <= (w_b == '0);
            r_a       <= ReadData1;
            if ((w_op == OP_DIV) || (w_op == OP_DIVU)) begin
                r_p <= {{WIDTH{1'b0}}, w_abs_a};
                r_m <= w_abs_b;
            end else begin
                r_p <= {{WIDTH{1'b0}}, w_abs_b};
                r_m <= w_abs_a;
            end
        end else if (Stall) begin
            r_cnt <= r_cnt + 1'b1;
            r_p   <= w_p_next;
            if (w_last) begin
                if (!r_div) begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end else if (r_bzero) begin
                    r_hi <= r_a;
                    r_lo <= '1;
                end else begin
                    r_hi <= w_r;
                    r_lo <= w_q;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            AluResult    <= '0;
            ReadData2Out <= '0;
            MemtoReg     <= 1'b0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            RegWrite     <= 1'b0;
            WriteReg     <= '0;
            OutValid     <= 1'b0;
        end else if (w_accept) begin
            AluResult    <= w_is_md ? '0 : w_alu;
            ReadData2Out <= ReadData2;
            MemtoReg     <= MemtoRegIn;
            MemRead      <= MemReadIn;
            MemWrite     <= MemWriteIn;
            RegWrite     <= RegWriteIn & ~w_is_md;
            WriteReg     <= WriteRegIn;
            OutValid     <= 1'b1;
        end else begin
            AluResult    <= '0;
            ReadData2Out <= '0;
            MemtoReg     <= 1'b0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            RegWrite     <= 1'b0;
            WriteReg     <= '0;
            OutValid     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Self-checking bench for ex_stage_muldiv: random ALU traffic and
// multiply/divide sequences compared against a plain-arithmetic model.
module tb_ex_stage_muldiv;
    logic        Clk = 1'b0;
    logic        Reset, InValid, ALUSrc;
    logic [31:0] ReadData1, ReadData2, SignExtImm;
    logic [3:0]  AluCtrl;
    logic [4:0]  Shamt, WriteRegIn, WriteReg;
    logic        MemtoRegIn, MemReadIn, MemWriteIn, RegWriteIn;
    logic        Stall, MemtoReg, MemRead, MemWrite, RegWrite, OutValid;
    logic [31:0] AluResult, ReadData2Out;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;

    ex_stage_muldiv #(.WIDTH(32), .MD_CYCLES(32)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .SignExtImm(SignExtImm),
        .ALUSrc(ALUSrc), .AluCtrl(AluCtrl), .Shamt(Shamt),
        .MemtoRegIn(MemtoRegIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
        .RegWriteIn(RegWriteIn), .WriteRegIn(WriteRegIn),
        .Stall(Stall), .AluResult(AluResult), .ReadData2Out(ReadData2Out),
        .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .OutValid(OutValid)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, b,
                                            input logic [4:0] sh);
        longint sb;
        sb = longint'($signed(b));
        case (c)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return 32'(longint'(a) + longint'(b));
            4'd3:  return 32'(longint'(b) * (longint'(1) << sh));
            4'd4:  return 32'(longint'(b) / (longint'(1) << sh));
            4'd5:  return 32'(sb >>> sh);
            4'd6:  return 32'(longint'(a) - longint'(b));
            4'd7:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd8:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'd9:  return a ^ b;
            4'd10: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_md(input logic [3:0] c, input logic [31:0] a, b,
                          output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        if (c == 4'd11) begin
            p = 64'(longint'(int'(a)) * longint'(int'(b)));
            hi = p[63:32]; lo = p[31:0];
        end else if (c == 4'd12) begin
            p = {32'd0, a} * {32'd0, b};
            hi = p[63:32]; lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a; lo = 32'hFFFFFFFF;
        end else if (c == 4'd13) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                hi = 32'd0; lo = 32'h80000000;
            end else begin
                lo = 32'(int'(a) / int'(b));
                hi = 32'(int'(a) % int'(b));
            end
        end else begin
            lo = a / b; hi = a % b;
        end
    endtask

    task automatic set_op(input logic [3:0] c, input logic [31:0] a, rd2, imm,
                          input logic src, input logic [4:0] sh,
                          input logic [3:0] ctl, input logic [4:0] wr);
        InValid = 1'b1; AluCtrl = c; ReadData1 = a; ReadData2 = rd2; SignExtImm = imm;
        ALUSrc = src; Shamt = sh; WriteRegIn = wr;
        {MemtoRegIn, MemReadIn, MemWriteIn, RegWriteIn} = ctl;
    endtask

    task automatic idle();
        set_op(4'd0, '0, '0, '0, 1'b0, 5'd0, 4'd0, 5'd0);
        InValid = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b1;
        repeat (2) tick();
        total++;
        if ({Stall, OutValid, MemtoReg, MemRead, MemWrite, RegWrite} !== 6'b0)
            $display("FAIL reset_ctrl got %b want 000000",
                     {Stall, OutValid, MemtoReg, MemRead, MemWrite, RegWrite});
        else passed++;
        total++;
        if ({AluResult, ReadData2Out, WriteReg} !== 69'd0)
            $display("FAIL reset_data got %h/%h/%h want 0", AluResult, ReadData2Out, WriteReg);
        else passed++;
        Reset = 1'b0;
    endtask

    task automatic test_load_add();
        set_op(4'd2, 32'd5, 32'd99, 32'd7, 1'b1, 5'd0, 4'b1101, 5'd8);
        tick();
        total++;
        if ({AluResult, MemRead, MemtoReg, OutValid, WriteReg} !== {32'd12, 3'b111, 5'd8})
            $display("FAIL load_add got %h %b%b%b %0d want 0000000c 111 8",
                     AluResult, MemRead, MemtoReg, OutValid, WriteReg);
        else passed++;
        idle();
        tick();
        total++;
        if ({OutValid, MemRead, MemtoReg, RegWrite, AluResult, ReadData2Out} !== 68'd0)
            $display("FAIL bubble got v=%b r=%h d=%h want all 0", OutValid, AluResult, ReadData2Out);
        else passed++;
    endtask

    task automatic test_slt_sra();
        logic [31:0] want [3] = '{32'd1, 32'd0, 32'hF8000000};
        logic [3:0]  ops  [3] = '{4'd7, 4'd8, 4'd5};
        for (int i = 0; i < 3; i++) begin
            if (i < 2) set_op(ops[i], 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd0, 4'b0001, 5'd2);
            else       set_op(ops[i], 32'd0, 32'h80000000, 32'd0, 1'b0, 5'd4, 4'b0001, 5'd2);
            tick();
            total++;
            if (AluResult !== want[i])
                $display("FAIL slt_sra[%0d] got %h want %h", i, AluResult, want[i]);
            else passed++;
        end
        idle();
    endtask

    task automatic test_alu_random();
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  c;
            logic [31:0] a, rd2, imm, b, exp;
            logic        src, v;
            logic [4:0]  sh, wr;
            logic [3:0]  ctl;
            c = 4'($urandom_range(0, 10));
            a = $urandom; rd2 = $urandom; imm = $urandom;
            src = 1'($urandom); sh = 5'($urandom); wr = 5'($urandom); ctl = 4'($urandom);
            v = ($urandom_range(0, 3) != 0);
            b = src ? imm : rd2;
            set_op(c, a, rd2, imm, src, sh, ctl, wr);
            InValid = v;
            exp = ref_alu(c, a, b, sh);
            tick();
            total++;
            if (v && {OutValid, AluResult, ReadData2Out, RegWrite, MemWrite, WriteReg} !==
                     {1'b1, exp, rd2, ctl[0], ctl[1], wr})
                $display("FAIL alu_rand op=%0d got %h/%h v=%b want %h/%h", c, AluResult,
                         ReadData2Out, OutValid, exp, rd2);
            else if (!v && {OutValid, AluResult, ReadData2Out, RegWrite, MemWrite, WriteReg} !== 71'd0)
                $display("FAIL alu_bubble got v=%b %h want 0", OutValid, AluResult);
            else passed++;
        end
        idle();
    endtask

    task automatic test_md(input logic [3:0] c, input logic [31:0] a, b);
        int          n;
        logic [31:0] ha, hi;
        ref_md(c, a, b, m_hi, m_lo);
        set_op(c, a, b, 32'd0, 1'b0, 5'd0, 4'b0001, 5'd9);
        tick();
        total++;
        if ({Stall, OutValid, RegWrite, AluResult} !== {3'b110, 32'd0})
            $display("FAIL md_issue op=%0d got s=%b v=%b rw=%b r=%h want 1 1 0 0",
                     c, Stall, OutValid, RegWrite, AluResult);
        else passed++;
        ha = $urandom; hi = $urandom;
        set_op(4'd2, ha, 32'd0, hi, 1'b1, 5'd0, 4'b0001, 5'd3);
        n = 1;
        for (int k = 0; k < 40 && Stall; k++) begin
            tick();
            if (Stall) n++;
            total++;
            if (OutValid !== 1'b0) $display("FAIL md_hold_bubble got v=%b want 0", OutValid);
            else passed++;
        end
        total++;
        if (n !== 32) $display("FAIL md_busy_len op=%0d got %0d want 32", c, n);
        else passed++;
        tick();
        total++;
        if ({OutValid, AluResult} !== {1'b1, 32'(ha + hi)})
            $display("FAIL md_held_add got v=%b %h want 1 %h", OutValid, AluResult, 32'(ha + hi));
        else passed++;
        set_op(4'd15, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0001, 5'd4);
        tick();
        total++;
        if (AluResult !== m_hi)
            $display("FAIL mfhi op=%0d a=%h b=%h got %h want %h", c, a, b, AluResult, m_hi);
        else passed++;
        ALUSrc = 1'b1;
        tick();
        total++;
        if (AluResult !== m_lo)
            $display("FAIL mflo op=%0d a=%h b=%h got %h want %h", c, a, b, AluResult, m_lo);
        else passed++;
        idle();
    endtask

    task automatic test_md_random();
        for (int i = 0; i < 8; i++) begin
            logic [3:0]  c;
            logic [31:0] a, b;
            c = 4'($urandom_range(11, 14));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 :
                ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if ($urandom_range(0, 1) == 0) b = -b;
            test_md(c, a, b);
        end
    endtask

    task automatic test_reset_midop();
        set_op(4'd12, $urandom, $urandom, 32'd0, 1'b0, 5'd0, 4'b0001, 5'd1);
        tick();
        idle();
        repeat (10) tick();
        Reset = 1'b1;
        #1;
        total++;
        if ({Stall, OutValid, AluResult} !== 34'd0)
            $display("FAIL reset_midop got s=%b v=%b r=%h want 0", Stall, OutValid, AluResult);
        else passed++;
        #1;
        Reset = 1'b0;
        m_hi = '0; m_lo = '0;
        set_op(4'd15, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0001, 5'd4);
        tick();
        total++;
        if ({Stall, AluResult} !== {1'b0, m_hi}) $display("FAIL reset_hi got %h want 0", AluResult);
        else passed++;
        ALUSrc = 1'b1;
        tick();
        total++;
        if (AluResult !== m_lo) $display("FAIL reset_lo got %h want 0", AluResult);
        else passed++;
        set_op(4'd2, 32'd20, 32'd0, 32'd22, 1'b1, 5'd0, 4'b0001, 5'd6);
        tick();
        total++;
        if ({OutValid, RegWrite, AluResult} !== {2'b11, 32'd42})
            $display("FAIL reset_add got %b%b %h want 11 0000002a", OutValid, RegWrite, AluResult);
        else passed++;
        idle();
    endtask

    task automatic test_store();
        set_op(4'd2, 32'h100, 32'hDEADBEEF, 32'd4, 1'b1, 5'd0, 4'b0010, 5'd0);
        tick();
        total++;
        if ({AluResult, ReadData2Out, MemWrite, RegWrite, MemRead, OutValid} !==
            {32'h104, 32'hDEADBEEF, 4'b1001})
            $display("FAIL store got %h %h mw=%b rw=%b want 00000104 deadbeef 1 0",
                     AluResult, ReadData2Out, MemWrite, RegWrite);
        else passed++;
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_slt_sra();
        test_alu_random();
        test_md(4'd11, -32'sd3, 32'd7);
        test_md(4'd13, -32'sd7, 32'd2);
        test_md(4'd14, 32'd9, 32'd0);
        test_md(4'd13, 32'h80000000, 32'hFFFFFFFF);
        test_md(4'd13, 32'h12345678, 32'd0);
        test_md_random();
        test_reset_midop();
        test_store();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ex_stage_muldiv.md
Name: ex_stage_muldiv

Overview:
Execute stage plus EX/MEM pipeline register that directly feeds MEMandWB: produces AluResult (ALU value or load/store address), ReadData2 (store data) and the MemtoReg/MemRead/MemWrite controls. Single-cycle ALU ops complete in one clock. MULT/MULTU/DIV/DIVU run on an iterative 32-cycle unit writing HI/LO, and stall upstream while busy. MFHI/MFLO read HI/LO.

Parameters:
WIDTH, 32, datapath width (ops and tests assume 32)
MD_CYCLES, 32, iterations per multiply/divide (must equal WIDTH)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
InValid  input  1  instruction present at EX inputs
ReadData1  input  32  rs operand
ReadData2  input  32  rt operand / store data
SignExtImm  input  32  sign-extended immediate
ALUSrc  input  1  1: B = SignExtImm; 0: B = ReadData2
AluCtrl  input  4  operation select (see Behaviour)
Shamt  input  5  shift amount
MemtoRegIn, MemReadIn, MemWriteIn, RegWriteIn  input  1 each  control from decode
WriteRegIn  input  5  destination register
Stall  output  1  upstream must hold inputs this cycle
AluResult  output  32  registered result to MEM
ReadData2Out  output  32  registered store data
MemtoReg, MemRead, MemWrite, RegWrite  output  1 each  registered control
WriteReg  output  5  registered destination
OutValid  output  1  EX/MEM slot holds a real instruction

Behaviour:
- Reset (async): all outputs, HI, LO, busy flag, iteration counter = 0. Reset during a MUL/DIV aborts it; HI/LO stay 0.
- AluCtrl: 0 AND, 1 OR, 2 ADD, 3 SLL(B<<Shamt), 4 SRL, 5 SRA, 6 SUB, 7 SLT (signed, result 0/1), 8 SLTU, 9 XOR, 10 NOR, 11 MULT, 12 MULTU, 13 DIV, 14 DIVU, 15 MFHI when ALUSrc=0 / MFLO when ALUSrc=1. A = ReadData1.
- ADD/SUB wrap mod 2^32, no overflow trap.
- Accept = InValid & ~Busy. On accept the EX/MEM register loads: AluResult = op result, ReadData2Out = ReadData2, control/WriteReg copied, OutValid=1. Latency 1 clock.
- Bubble (no accept, or Busy): EX/MEM loads OutValid=0, MemRead=MemWrite=RegWrite=MemtoReg=0, WriteReg=0, AluResult=0, ReadData2Out=0.
- Ops 11-14 on accept: latch A/B, Busy=1, counter=0; EX/MEM gets the op with RegWrite forced to 0, AluResult=0.
- Busy FSM: IDLE -> RUN on MD accept; RUN: one shift-add (mult) or restoring-subtract (div) step per clock, counter++; on the 32nd RUN edge write HI/LO and return to IDLE. Busy is high exactly 32 cycles.
- Stall = Busy (combinational from register). While Stall=1, inputs are ignored and a bubble is produced.
- MULT/MULTU: {HI,LO} = 64-bit product, signed/unsigned.
- DIV: LO = quotient truncated toward zero, HI = remainder with dividend's sign. DIVU unsigned.
- Divide by zero (either): LO = 32'hFFFFFFFF, HI = dividend; still 32 busy cycles.
- 0x80000000 / -1 (DIV): LO = 0x80000000, HI = 0.
- MFHI/MFLO issued after a MUL/DIV are stalled until Busy=0, then read the new HI/LO (no hazard window).

Test Plan:
- Reset, then ADD A=5, imm=7, ALUSrc=1, MemReadIn=1, MemtoRegIn=1 -> next edge AluResult=12, MemRead=1, MemtoReg=1, OutValid=1.
- SLT A=0xFFFFFFFF, B=1 -> AluResult=1; SLTU same operands -> 0; SRA 0x80000000 by 4 -> 0xF8000000.
- MULT A=-3, B=7 -> Stall high exactly 32 cycles, then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFEB; an ADD presented during Busy is held and completes one cycle after Stall falls.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 9/0 -> LO=0xFFFFFFFF, HI=9.
- Assert Reset at iteration 10 of a MULTU -> Stall=0, HI=LO=0, outputs 0 immediately; next ADD behaves normally.
- SW: ADD A=0x100, imm=4, ReadData2=0xDEADBEEF, MemWriteIn=1 -> AluResult=0x104, ReadData2Out=0xDEADBEEF, MemWrite=1, RegWrite=0.
